bus_rx_endpoint: RTL and testbench

- Receiving endpoint for one output port of bs_gnrtr_n_rbtr: consumes the bus's per-driver push strobe and D_push packet.
- Filters packets by destination ID, buffers accepted packets in a show-ahead FIFO, and presents them to a local consumer via pndng/pop.
- One instance per driver index; it is the synthesizable counterpart to the input FIFO the bus reads from.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/bus_sync_fifo.sv | 82 ++++++++
 rtl/bus_rx_endpoint.sv | 93 +++++++++
 tb/tb_bus_rx_endpoint.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus receive path: address constants, the
// destination-extraction helper and the saturating event-counter type.
package bus_pkg;

   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

   // Widest packet the helper accepts; callers left-align into this width.
   localparam int MAX_PKT_W = 1024;

   typedef logic [7:0] sat_cnt_t;

   // Destination ID is the top ID_W bits of a left-aligned packet.
   function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt);
      return pkt[MAX_PKT_W-1 -: ID_W];
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
      if (c == 8'hFF) begin
         return c;
      end else begin
         return c + 8'd1;
      end
   endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Show-ahead synchronous FIFO. Occupancy is tracked explicitly; a read in the
// same cycle frees a slot so a write into a full FIFO can still land.
module bus_sync_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [width-1:0]         rd_data,
   output logic                     not_empty,
   output logic                     full,
   output logic [$clog2(depth):0]   count,
   output logic                     drop
);

   localparam int PW = $clog2(depth);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(depth);

   logic [width-1:0] mem_r [depth];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_read_s;
   logic             do_write_s;

   // Decide which accesses are honoured; reads on empty are ignored.
   always_comb begin
      do_read_s  = 1'b0;
      do_write_s = 1'b0;
      drop       = 1'b0;
      if (rd_en && (count_r != CW'(0))) begin
         do_read_s = 1'b1;
      end else begin
         do_read_s = 1'b0;
      end
      if (wr_en && ((count_r != FULL_CNT) || do_read_s)) begin
         do_write_s = 1'b1;
      end else if (wr_en) begin
         drop = 1'b1;
      end else begin
         do_write_s = 1'b0;
      end
   end

   // Pointer and occupancy registers; reset discards all stored entries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_write_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_read_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_write_s, do_read_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (do_write_s && !reset) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign count     = count_r;
   assign not_empty = (count_r != CW'(0));
   assign full      = (count_r == FULL_CNT);
   assign rd_data   = not_empty ? mem_r[rd_ptr_r] : {width{1'b0}};

endmodule

// File: rtl/bus_rx_endpoint.sv
// Receiving endpoint for one bus output port: filters packets by destination
// ID (own ID or broadcast), queues accepted packets, and counts drops.
module bus_rx_endpoint
   import bus_pkg::*;
#(
   parameter int              width = 16,
   parameter int              depth = 8,
   parameter logic [ID_W-1:0] id    = 8'd0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [width-1:0]         D_push,
   input  logic                     pop,
   output logic [width-1:0]         D_pop,
   output logic                     pndng,
   output logic                     full,
   output logic [$clog2(depth):0]   count,
   output logic [7:0]               ovf_cnt,
   output logic [7:0]               misroute_cnt
);

   logic [ID_W-1:0] dest_s;
   logic            accept_s;
   logic            misroute_s;
   logic            drop_s;
   sat_cnt_t        ovf_cnt_r;
   sat_cnt_t        misroute_cnt_r;
   sat_cnt_t        ovf_cnt_nxt_s;
   sat_cnt_t        misroute_cnt_nxt_s;

   assign dest_s = get_dest({D_push, {(MAX_PKT_W-width){1'b0}}});

   // Address filter: own ID or broadcast goes to the FIFO, anything else is a misroute.
   always_comb begin
      accept_s   = 1'b0;
      misroute_s = 1'b0;
      if (push && ((dest_s == id) || (dest_s == BCAST_ID))) begin
         accept_s = 1'b1;
      end else if (push) begin
         misroute_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   bus_sync_fifo #(
      .width (width),
      .depth (depth)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (accept_s),
      .wr_data   (D_push),
      .rd_en     (pop),
      .rd_data   (D_pop),
      .not_empty (pndng),
      .full      (full),
      .count     (count),
      .drop      (drop_s)
   );

   // Next values of the two drop counters, saturating at 255.
   always_comb begin
      ovf_cnt_nxt_s      = ovf_cnt_r;
      misroute_cnt_nxt_s = misroute_cnt_r;
      if (drop_s) begin
         ovf_cnt_nxt_s = sat_inc(ovf_cnt_r);
      end else begin
         ovf_cnt_nxt_s = ovf_cnt_r;
      end
      if (misroute_s) begin
         misroute_cnt_nxt_s = sat_inc(misroute_cnt_r);
      end else begin
         misroute_cnt_nxt_s = misroute_cnt_r;
      end
   end

   // Drop counters clear only on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt_r      <= 8'd0;
         misroute_cnt_r <= 8'd0;
      end else begin
         ovf_cnt_r      <= ovf_cnt_nxt_s;
         misroute_cnt_r <= misroute_cnt_nxt_s;
      end
   end

   assign ovf_cnt      = ovf_cnt_r;
   assign misroute_cnt = misroute_cnt_r;

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Scoreboard bench for bus_rx_endpoint (width=16, depth=4, id=3).
module tb_bus_rx_endpoint;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam logic [7:0] ID = 8'd3;

   logic              clk;
   logic              reset;
   logic              push;
   logic [WIDTH-1:0]  D_push;
   logic              pop;
   logic [WIDTH-1:0]  D_pop;
   logic              pndng;
   logic              full;
   logic [2:0]        count;
   logic [7:0]        ovf_cnt;
   logic [7:0]        misroute_cnt;

   int                checks = 0;
   int                errors = 0;
   int                model_cnt = 0;
   logic [WIDTH-1:0]  exp_q [$];

   bus_rx_endpoint #(
      .width (WIDTH),
      .depth (DEPTH),
      .id    (ID)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .D_push       (D_push),
      .pop          (pop),
      .D_pop        (D_pop),
      .pndng        (pndng),
      .full         (full),
      .count        (count),
      .ovf_cnt      (ovf_cnt),
      .misroute_cnt (misroute_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every honoured pop must present the oldest expected packet.
   always @(negedge clk) begin
      logic [WIDTH-1:0] exp_word;
      if (!reset && pop && pndng) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL pop_data: got %h, expected nothing (scoreboard empty)", D_pop);
         end else begin
            exp_word = exp_q.pop_front();
            if (D_pop !== exp_word) begin
               errors = errors + 1;
               $display("FAIL pop_data: got %h, expected %h", D_pop, exp_word);
            end
         end
      end
   end

   // Issue one cycle of stimulus and record what should land in the FIFO.
   task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic po);
      logic rd;
      logic hit;
      logic wr;
      @(posedge clk);
      #1;
      push   = p;
      D_push = d;
      pop    = po;
      rd  = po && (model_cnt > 0);
      hit = (d[15:8] == ID) || (d[15:8] == 8'hFF);
      wr  = p && hit && ((model_cnt < DEPTH) || rd);
      if (wr) exp_q.push_back(d);
      model_cnt = model_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
   endtask

   task automatic cmp(input string name, input int got, input int want);
      checks = checks + 1;
      if (got != want) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Compare visible state against hand-computed occupancy and counter values.
   task automatic check(input string name, input int e_cnt, input int e_ovf, input int e_mis);
      logic [WIDTH-1:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
      cmp({name, ".count"},    int'(count),        e_cnt);
      cmp({name, ".pndng"},    int'(pndng),        (e_cnt != 0) ? 1 : 0);
      cmp({name, ".full"},     int'(full),         (e_cnt == DEPTH) ? 1 : 0);
      cmp({name, ".ovf"},      int'(ovf_cnt),      e_ovf);
      cmp({name, ".misroute"}, int'(misroute_cnt), e_mis);
      cmp({name, ".D_pop"},    int'(D_pop),        int'(head));
   endtask

   task automatic idle();
      step(1'b0, 16'h0000, 1'b0);
   endtask

   initial begin
      reset  = 1'b1;
      push   = 1'b0;
      D_push = 16'h0000;
      pop    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset", 0, 0, 0);

      step(1'b1, 16'h03AA, 1'b0); idle();
      check("first_push", 1, 0, 0);
      step(1'b0, 16'h0000, 1'b1); idle();
      check("first_pop", 0, 0, 0);

      step(1'b1, 16'h05BB, 1'b0); idle();
      check("misroute", 0, 0, 1);
      step(1'b1, 16'hFF11, 1'b0); idle();
      check("broadcast", 1, 0, 1);
      step(1'b0, 16'h0000, 1'b1); idle();
      check("broadcast_pop", 0, 0, 1);

      for (int i = 1; i <= 5; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0);
      idle();
      check("overflow", 4, 1, 1);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
      idle();
      check("drain", 0, 1, 1);

      for (int i = 1; i <= 4; i++) step(1'b1, 16'h0310 + 16'(i), 1'b0);
      idle();
      check("refill", 4, 1, 1);
      step(1'b1, 16'h0399, 1'b1); idle();
      check("full_push_pop", 4, 1, 1);
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
      idle();
      check("drain2", 0, 1, 1);

      step(1'b0, 16'h0000, 1'b1); idle();
      check("empty_pop", 0, 1, 1);
      step(1'b1, 16'h0377, 1'b1); idle();
      check("empty_push_pop", 1, 1, 1);
      step(1'b0, 16'h0000, 1'b1); idle();
      check("empty_push_pop_drain", 0, 1, 1);

      for (int i = 1; i <= 3; i++) step(1'b1, 16'h0320 + 16'(i), 1'b0);
      idle();
      check("fill3", 3, 1, 1);
      #3;
      reset = 1'b1;
      exp_q.delete();
      model_cnt = 0;
      #1;
      check("mid_reset", 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 260; i++) step(1'b1, 16'h0700 + 16'(i % 256), 1'b0);
      idle();
      check("misroute_sat", 0, 0, 255);
      step(1'b1, 16'hFF42, 1'b0); idle();
      check("after_reset", 1, 0, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
